// File: rtl/audio_frame_sequencer_if.sv
// Bus bundle between the frame sequencer and its environment: buffer
// read port, frame-start controls, streamed sample handshake and status.
interface audio_frame_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 24
);
    logic              i_enable;
    logic              i_buffer_ready;
    logic [ADDR_W-1:0] o_read_addr;
    logic [DATA_W-1:0] i_audio_sample;
    logic [DATA_W-1:0] o_sample_data;
    logic              o_sample_valid;
    logic              i_sample_ready;
    logic              o_sample_last;
    logic              o_busy;
    logic [7:0]        o_overrun_cnt;
    logic [15:0]       o_frame_cnt;

    // Sequencer side
    modport master (
        input  i_enable,
        input  i_buffer_ready,
        input  i_audio_sample,
        input  i_sample_ready,
        output o_read_addr,
        output o_sample_data,
        output o_sample_valid,
        output o_sample_last,
        output o_busy,
        output o_overrun_cnt,
        output o_frame_cnt
    );

    // Buffer / consumer / controller side
    modport slave (
        output i_enable,
        output i_buffer_ready,
        output i_audio_sample,
        output i_sample_ready,
        input  o_read_addr,
        input  o_sample_data,
        input  o_sample_valid,
        input  o_sample_last,
        input  o_busy,
        input  o_overrun_cnt,
        input  o_frame_cnt
    );
endinterface

// File: rtl/audio_frame_sequencer.sv
// Audio frame sequencer: on each "buffer complete" rising edge, reads
// FRAME_LEN samples out of the finished buffer half (fixed read latency)
// and streams them downstream with a valid/ready handshake. Frames that
// arrive while one is still streaming are dropped and counted, except
// one landing exactly on the final handshake, which chains seamlessly.
module audio_frame_sequencer #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 24,
    parameter int FRAME_LEN = 512,
    parameter int READ_LAT  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    audio_frame_sequencer_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [1:0]        LAT_LOAD  = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        PRESENT
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        lat_reg;
    logic              ready_prev_reg;
    logic [DATA_W-1:0] data_reg;
    logic              valid_reg;
    logic              last_reg;
    logic              busy_reg;
    logic [7:0]        overrun_reg;
    logic [15:0]       frame_cnt_reg;

    logic rise;
    logic handshake;
    logic final_hs;
    logic drop;

    // Edge detect, handshake and overrun qualification
    assign rise      = bus.i_buffer_ready & ~ready_prev_reg;
    assign handshake = valid_reg & bus.i_sample_ready;
    assign final_hs  = handshake & (addr_reg == LAST_ADDR);
    // A new frame arriving mid-stream is lost, unless it coincides with
    // the final handshake (then it is either chained or, if disabled, ignored).
    assign drop      = rise & (state_reg != IDLE) & ~final_hs;

    assign bus.o_read_addr    = addr_reg;
    assign bus.o_sample_data  = data_reg;
    assign bus.o_sample_valid = valid_reg;
    assign bus.o_sample_last  = last_reg;
    assign bus.o_busy         = busy_reg;
    assign bus.o_overrun_cnt  = overrun_reg;
    assign bus.o_frame_cnt    = frame_cnt_reg;

    // Frame FSM with all outputs registered; address counter doubles as read address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            lat_reg        <= '0;
            ready_prev_reg <= 1'b0;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            last_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            overrun_reg    <= '0;
            frame_cnt_reg  <= '0;
        end else begin
            ready_prev_reg <= bus.i_buffer_ready;

            if (drop && (overrun_reg != 8'hFF)) begin
                overrun_reg <= overrun_reg + 8'd1;
            end

            case (state_reg)
                IDLE: begin
                    if (rise && bus.i_enable) begin
                        addr_reg  <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ISSUE;
                    end
                end

                ISSUE: begin
                    lat_reg   <= LAT_LOAD;
                    state_reg <= WAIT;
                end

                WAIT: begin
                    if (lat_reg == 2'd0) begin
                        data_reg  <= bus.i_audio_sample;
                        valid_reg <= 1'b1;
                        last_reg  <= (addr_reg == LAST_ADDR);
                        state_reg <= PRESENT;
                    end else begin
                        lat_reg <= lat_reg - 2'd1;
                    end
                end

                PRESENT: begin
                    if (handshake) begin
                        valid_reg <= 1'b0;
                        last_reg  <= 1'b0;
                        if (addr_reg != LAST_ADDR) begin
                            addr_reg  <= addr_reg + ADDR_W'(1);
                            state_reg <= ISSUE;
                        end else begin
                            frame_cnt_reg <= frame_cnt_reg + 16'd1;
                            if (rise && bus.i_enable) begin
                                // Back-to-back frame: restart without leaving busy
                                addr_reg  <= '0;
                                state_reg <= ISSUE;
                            end else begin
                                busy_reg  <= 1'b0;
                                state_reg <= IDLE;
                            end
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Self-checking bench for audio_frame_sequencer: a table of frame-level
// vectors plus hand-written sequences for chaining and mid-frame reset.
// A negedge monitor checks every handshake against the expected ramp.
module tb_audio_frame_sequencer;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 24;
    localparam int FRAME_LEN = 512;
    localparam int READ_LAT  = 1;
    localparam int LAST      = FRAME_LEN - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    audio_frame_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    audio_frame_sequencer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .FRAME_LEN(FRAME_LEN),
        .READ_LAT (READ_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Buffer model: word[n] = n, registered read (READ_LAT = 1)
    logic [DATA_W-1:0] mem [FRAME_LEN];
    always @(posedge clk) bus.i_audio_sample <= mem[bus.o_read_addr];

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int cyc         = 0;
    int hs_count    = 0;
    int exp_idx     = 0;
    int last_hs_cyc = -100;
    logic              prev_valid = 1'b0;
    logic              prev_ready = 1'b0;
    logic              prev_last  = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            exp_idx     = 0;
            last_hs_cyc = -100;
            prev_valid  = 1'b0;
            prev_ready  = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("stall_valid_held", bus.o_sample_valid, 1);
                check("stall_data_stable", bus.o_sample_data, prev_data);
                check("stall_last_stable", bus.o_sample_last, prev_last);
            end
            if (prev_valid && prev_ready)
                check("valid_low_after_hs", bus.o_sample_valid, 0);
            if (!bus.o_sample_valid)
                check("last_without_valid", bus.o_sample_last, 0);
            if (bus.o_sample_valid && bus.i_sample_ready) begin
                check("hs_data", bus.o_sample_data, exp_idx);
                check("hs_last", bus.o_sample_last, (exp_idx == LAST) ? 1 : 0);
                if (last_hs_cyc >= 0)
                    check("hs_spacing_min", ((cyc - last_hs_cyc) >= READ_LAT + 2) ? 1 : 0, 1);
                exp_idx     = (exp_idx + 1) % FRAME_LEN;
                hs_count++;
                last_hs_cyc = cyc;
            end
            prev_valid = bus.o_sample_valid;
            prev_ready = bus.i_sample_ready;
            prev_last  = bus.o_sample_last;
            prev_data  = bus.o_sample_data;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset (asynchronously), verify every output is 0, then release
    task automatic do_reset(input logic buf_level);
        reset              = 1'b0;
        bus.i_buffer_ready = buf_level;
        bus.i_enable       = 1'b0;
        bus.i_sample_ready = 1'b1;
        #1;
        check("rst_read_addr", bus.o_read_addr, 0);
        check("rst_sample_data", bus.o_sample_data, 0);
        check("rst_sample_valid", bus.o_sample_valid, 0);
        check("rst_sample_last", bus.o_sample_last, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_overrun_cnt", bus.o_overrun_cnt, 0);
        check("rst_frame_cnt", bus.o_frame_cnt, 0);
        repeat (2) tick();
        reset    = 1'b1;
        hs_count = 0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c = 0;
        while (bus.o_busy && c < budget) begin
            tick();
            c++;
        end
        check({name, "_done_in_budget"}, bus.o_busy, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string name;
        bit    en;
        bit    rand_ready;
        int    edge_at;      // hs index for an extra rising edge, -1 = none
        int    drop_en_at;   // hs index to deassert i_enable, -1 = never
        int    storm;        // cycles of i_buffer_ready toggling, 0 = none
        int    exp_samples;
        int    exp_overrun;
        int    exp_frames;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit edge_done;
        bit found;

        for (int n = 0; n < FRAME_LEN; n++) mem[n] = DATA_W'(n);
        bus.i_enable       = 1'b0;
        bus.i_buffer_ready = 1'b0;
        bus.i_sample_ready = 1'b1;

        vecs[0] = '{"full_frame_ready_tied", 1, 0, -1, -1, 0,   512, 0,   1};
        vecs[1] = '{"random_backpressure",   1, 1, -1, -1, 0,   512, 0,   1};
        vecs[2] = '{"overrun_at_100",        1, 0, 100, -1, 0,  512, 1,   1};
        vecs[3] = '{"disabled_edge_idle",    0, 0, -1, -1, 0,   0,   0,   0};
        vecs[4] = '{"enable_drop_at_200",    1, 0, -1, 200, 0,  512, 0,   1};
        vecs[5] = '{"overrun_saturation",    1, 0, -1, -1, 600, 512, 255, 1};

        foreach (vecs[k]) begin
            do_reset(1'b0);
            tick();
            tick();
            bus.i_enable       = vecs[k].en;
            bus.i_buffer_ready = 1'b1;
            edge_done          = 1'b0;
            for (int c = 0; c < 8000; c++) begin
                tick();
                bus.i_sample_ready = vecs[k].rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (vecs[k].drop_en_at >= 0 && hs_count >= vecs[k].drop_en_at)
                    bus.i_enable = 1'b0;
                if (vecs[k].edge_at >= 0 && !edge_done && hs_count >= vecs[k].edge_at) begin
                    if (bus.i_buffer_ready) begin
                        bus.i_buffer_ready = 1'b0;
                    end else begin
                        bus.i_buffer_ready = 1'b1;
                        edge_done          = 1'b1;
                    end
                end
                if (c >= 2 && c < vecs[k].storm)
                    bus.i_buffer_ready = ~bus.i_buffer_ready;
                if (c >= 20 && c >= vecs[k].storm && !bus.o_busy) break;
            end
            bus.i_sample_ready = 1'b1;
            check({vecs[k].name, "_done_in_budget"}, bus.o_busy, 0);
            tick();
            check({vecs[k].name, "_samples"}, hs_count, vecs[k].exp_samples);
            check({vecs[k].name, "_overrun"}, bus.o_overrun_cnt, vecs[k].exp_overrun);
            check({vecs[k].name, "_frames"}, bus.o_frame_cnt, vecs[k].exp_frames);
            check({vecs[k].name, "_valid_idle"}, bus.o_sample_valid, 0);
            $display("vector %s: samples=%0d overrun=%0d frames=%0d",
                     vecs[k].name, hs_count, bus.o_overrun_cnt, bus.o_frame_cnt);
        end

        // Back-to-back: rising edge in the same cycle as the final handshake
        do_reset(1'b0);
        tick();
        tick();
        bus.i_enable       = 1'b1;
        bus.i_buffer_ready = 1'b1;
        tick();
        tick();
        bus.i_buffer_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 4000 && !found; c++) begin
            tick();
            if (bus.o_sample_valid && bus.o_sample_last) begin
                bus.i_buffer_ready = 1'b1;
                found = 1'b1;
                tick();
                check("b2b_busy_stays", bus.o_busy, 1);
                check("b2b_addr_restart", bus.o_read_addr, 0);
                check("b2b_frame_cnt_first", bus.o_frame_cnt, 1);
                bus.i_buffer_ready = 1'b0;
            end
        end
        check("b2b_edge_placed", found, 1);
        wait_idle(4000, "b2b");
        tick();
        check("b2b_samples", hs_count, 2 * FRAME_LEN);
        check("b2b_frames", bus.o_frame_cnt, 2);
        check("b2b_overrun", bus.o_overrun_cnt, 0);
        $display("sequence back_to_back: samples=%0d overrun=%0d frames=%0d",
                 hs_count, bus.o_overrun_cnt, bus.o_frame_cnt);

        // Mid-frame reset at sample 300, buffer_ready held high across reset
        do_reset(1'b0);
        tick();
        tick();
        bus.i_enable       = 1'b1;
        bus.i_buffer_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 4000 && !found; c++) begin
            tick();
            if (hs_count >= 300 && bus.o_sample_valid) found = 1'b1;
        end
        check("midrst_reached_300", found, 1);
        do_reset(1'b1);
        bus.i_enable = 1'b1;
        tick();
        check("midrst_restart_first_edge", bus.o_busy, 1);
        check("midrst_restart_addr", bus.o_read_addr, 0);
        wait_idle(4000, "midrst");
        tick();
        check("midrst_samples", hs_count, FRAME_LEN);
        check("midrst_frames", bus.o_frame_cnt, 1);
        check("midrst_overrun", bus.o_overrun_cnt, 0);
        $display("sequence mid_frame_reset: samples=%0d overrun=%0d frames=%0d",
                 hs_count, bus.o_overrun_cnt, bus.o_frame_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
